periph_bus_decoder: RTL and testbench

- Initiator side of the peripheral register bus; the read-data mux is the return end of this bus.
- Accepts one read or write transaction at a time from the host command interface (SPI command layer), decodes the address and drives a one-hot select plus a single-cycle strobe to pps_div[0..3], pulse_gen[0..3] or main memory.
- For reads, waits the fixed return latency of the peripheral plus the OR-mux, captures the returned byte and acknowledges the host.

---
 rtl/periph_bus_pkg.sv | 28 ++
 rtl/periph_addr_decode.sv | 41 ++++
 rtl/periph_bus_decoder.sv | 146 ++++++++++++++
 tb/tb_periph_bus_decoder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : periph_bus_pkg
// Brief    : Shared types and constants for the peripheral register bus.
// Revision : 1.0
// ============================================================================
package periph_bus_pkg;

    localparam int c_addr_w = 8;
    localparam int c_data_w = 8;
    localparam int c_offs_w = 6;

    typedef enum logic [1:0] {
        REG_PPS   = 2'b00,
        REG_PULSE = 2'b01,
        REG_MEM   = 2'b10,
        REG_NONE  = 2'b11
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/periph_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : periph_addr_decode
// Brief    : Splits a host address into region, instance index and local offset.
// Revision : 1.0
// ============================================================================
module periph_addr_decode
    import periph_bus_pkg::*;
(
    input  logic [c_addr_w-1:0] i_addr,
    output region_t             o_region,
    output logic [1:0]          o_index,
    output logic [c_offs_w-1:0] o_offset
);

    always_comb begin
        o_region = REG_NONE;
        o_index  = i_addr[5:4];
        o_offset = '0;
        case (i_addr[7:6])
            2'b00: begin
                o_region = REG_PPS;
                o_offset = {2'b00, i_addr[3:0]};
            end
            2'b01: begin
                o_region = REG_PULSE;
                o_offset = {2'b00, i_addr[3:0]};
            end
            2'b10: begin
                o_region = REG_MEM;
                o_offset = i_addr[5:0];
            end
            default: begin
                o_region = REG_NONE;
                o_offset = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/periph_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module   : periph_bus_decoder
// Brief    : Host-side initiator of the peripheral register bus: decodes one
//            transaction at a time, strobes the target and returns read data.
// Revision : 1.0
// ============================================================================
module periph_bus_decoder
    import periph_bus_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int N_PPS        = 4,
    parameter int N_PULSE      = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req,
    input  logic                i_we,
    input  logic [c_addr_w-1:0] i_addr,
    input  logic [c_data_w-1:0] i_wdata,
    output logic                o_busy,
    output logic                o_ack,
    output logic                o_err,
    output logic [c_data_w-1:0] o_rdata,
    output logic [N_PPS-1:0]    o_pps_sel,
    output logic [N_PULSE-1:0]  o_pulse_sel,
    output logic                o_mem_sel,
    output logic                o_wr_en,
    output logic                o_rd_en,
    output logic [c_offs_w-1:0] o_addr,
    output logic [c_data_w-1:0] o_wdata,
    input  logic [c_data_w-1:0] i_rd_data
);

    localparam logic [2:0] c_lat = 3'(READ_LATENCY);

    state_t                r_state;
    state_t                w_next;
    logic                  r_we;
    region_t               r_region;
    logic [1:0]            r_index;
    logic [c_offs_w-1:0]   r_offset;
    logic [c_data_w-1:0]   r_wdata;
    logic [c_data_w-1:0]   r_rdata;
    logic                  r_err;
    logic [2:0]            r_cnt;

    region_t               w_region;
    logic [1:0]            w_index;
    logic [c_offs_w-1:0]   w_offset;
    logic                  w_accept;
    logic                  w_access;

    periph_addr_decode u_decode (
        .i_addr   (i_addr),
        .o_region (w_region),
        .o_index  (w_index),
        .o_offset (w_offset)
    );

    assign w_accept = (r_state == ST_IDLE) && i_req;
    assign w_access = (r_state == ST_ACCESS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    w_next = (w_region == REG_NONE) ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: w_next = r_we ? ST_DONE : ST_WAIT;
            // r_cnt reaches 1 in the cycle where the returned byte is valid
            ST_WAIT:   if (r_cnt == 3'd1) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we     <= 1'b0;
            r_region <= REG_NONE;
            r_index  <= '0;
            r_offset <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= i_we;
                r_region <= w_region;
                r_index  <= w_index;
                r_offset <= w_offset;
                r_wdata  <= i_wdata;
                r_err    <= (w_region == REG_NONE);
                if (w_region == REG_NONE) begin
                    r_rdata <= '0;
                end
            end
            if (w_access) begin
                if (r_we) begin
                    r_rdata <= '0;
                end else begin
                    r_cnt <= c_lat;
                end
            end
            if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    r_rdata <= i_rd_data;
                end
            end
        end
    end

    assign o_busy    = (r_state != ST_IDLE);
    assign o_ack     = (r_state == ST_DONE);
    assign o_err     = o_ack && r_err;
    assign o_rdata   = r_rdata;
    assign o_mem_sel = w_access && (r_region == REG_MEM);
    assign o_wr_en   = w_access && r_we;
    assign o_rd_en   = w_access && !r_we;
    assign o_addr    = r_offset;
    assign o_wdata   = r_wdata;

    // Selects are only live during ACCESS so the read-mux OR sees one source
    for (genvar gi = 0; gi < N_PPS; gi++) begin : g_pps_sel
        assign o_pps_sel[gi] = w_access && (r_region == REG_PPS) && (r_index == 2'(gi));
    end

    for (genvar gi = 0; gi < N_PULSE; gi++) begin : g_pulse_sel
        assign o_pulse_sel[gi] = w_access && (r_region == REG_PULSE) && (r_index == 2'(gi));
    end

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_periph_bus_decoder
// Brief    : Scoreboard bench for periph_bus_decoder (latency 2 and 4 builds).
// Revision : 1.0
// ============================================================================
module tb_periph_bus_decoder;

    localparam int RL_A = 2;
    localparam int RL_B = 4;

    typedef struct {
        logic [3:0] pps;
        logic [3:0] pulse;
        logic       mem;
        logic       wr;
        logic       rd;
        logic [5:0] off;
        logic [7:0] wd;
        int         at;
    } stb_t;

    typedef struct {
        logic       err;
        logic [7:0] rdata;
        int         at;
    } ack_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       req      = 1'b0;
    logic       req_b    = 1'b0;
    logic       we       = 1'b0;
    logic [7:0] addr     = '0;
    logic [7:0] wdata    = '0;
    logic [7:0] rd_value = '0;
    logic [7:0] pipe_a   = '0;
    logic [7:0] pipe_b   = '0;
    logic [7:0] rd_a;
    logic [7:0] rd_b;
    int         cyc      = 0;
    int         n_chk    = 0;
    int         n_pass   = 0;
    int         c0_b;
    int         got_b;
    int         drained;

    logic       a_busy, a_ack, a_err, a_mem, a_wr, a_rd;
    logic [7:0] a_rdata, a_wdata;
    logic [3:0] a_pps, a_pulse;
    logic [5:0] a_addr;
    logic       b_busy, b_ack, b_err, b_mem, b_wr, b_rd;
    logic [7:0] b_rdata, b_wdata;
    logic [3:0] b_pps, b_pulse;
    logic [5:0] b_addr;

    stb_t stb_q[$];
    ack_t ack_q[$];
    stb_t se;
    ack_t ae;

    periph_bus_decoder #(.READ_LATENCY(RL_A), .N_PPS(4), .N_PULSE(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_busy(a_busy), .o_ack(a_ack), .o_err(a_err), .o_rdata(a_rdata),
        .o_pps_sel(a_pps), .o_pulse_sel(a_pulse), .o_mem_sel(a_mem),
        .o_wr_en(a_wr), .o_rd_en(a_rd), .o_addr(a_addr), .o_wdata(a_wdata), .i_rd_data(rd_a)
    );

    periph_bus_decoder #(.READ_LATENCY(RL_B), .N_PPS(4), .N_PULSE(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_busy(b_busy), .o_ack(b_ack), .o_err(b_err), .o_rdata(b_rdata),
        .o_pps_sel(b_pps), .o_pulse_sel(b_pulse), .o_mem_sel(b_mem),
        .o_wr_en(b_wr), .o_rd_en(b_rd), .o_addr(b_addr), .o_wdata(b_wdata), .i_rd_data(rd_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        pipe_a <= {pipe_a[6:0], a_rd};
        pipe_b <= {pipe_b[6:0], b_rd};
    end

    // Peripheral model: byte is driven only in the cycle it is due
    assign rd_a = pipe_a[RL_A-1] ? rd_value : 8'h00;
    assign rd_b = pipe_b[RL_B-1] ? rd_value : 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if ((|a_pps) || (|a_pulse) || a_mem || a_wr || a_rd) begin
                if (stb_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    se = stb_q.pop_front();
                    check("strobe_cycle", cyc, se.at);
                    check("pps_sel", {28'd0, a_pps}, {28'd0, se.pps});
                    check("pulse_sel", {28'd0, a_pulse}, {28'd0, se.pulse});
                    check("mem_sel", {31'd0, a_mem}, {31'd0, se.mem});
                    check("wr_en", {31'd0, a_wr}, {31'd0, se.wr});
                    check("rd_en", {31'd0, a_rd}, {31'd0, se.rd});
                    check("addr", {26'd0, a_addr}, {26'd0, se.off});
                    if (se.wr) check("wdata", {24'd0, a_wdata}, {24'd0, se.wd});
                end
            end
            if (a_ack) begin
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    ae = ack_q.pop_front();
                    check("ack_cycle", cyc, ae.at);
                    check("err", {31'd0, a_err}, {31'd0, ae.err});
                    check("rdata", {24'd0, a_rdata}, {24'd0, ae.rdata});
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] rv, input int hold);
        int   c0;
        bit   ok;
        stb_t s;
        ack_t k;
        logic [3:0] hi;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!a_busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("idle_timeout", 1, 0);
            return;
        end
        we = w; addr = a; wdata = d; rd_value = rv; req = 1'b1;
        c0 = cyc;
        hi = a[7:4];
        if (hi >= 4'hC) begin
            k.err = 1'b1; k.rdata = 8'h00; k.at = c0 + 1;
            ack_q.push_back(k);
        end else begin
            s.pps   = (hi < 4'h4) ? (4'b0001 << a[5:4]) : 4'b0000;
            s.pulse = (hi >= 4'h4 && hi < 4'h8) ? (4'b0001 << a[5:4]) : 4'b0000;
            s.mem   = (hi >= 4'h8);
            s.wr    = w;
            s.rd    = !w;
            s.off   = (hi >= 4'h8) ? a[5:0] : {2'b00, a[3:0]};
            s.wd    = d;
            s.at    = c0 + 1;
            stb_q.push_back(s);
            k.err   = 1'b0;
            k.rdata = w ? 8'h00 : rv;
            k.at    = w ? c0 + 2 : c0 + RL_A + 2;
            ack_q.push_back(k);
        end
        repeat (hold + 1) @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, a_busy}, 0);
        check("rst_ack", {31'd0, a_ack}, 0);
        check("rst_err", {31'd0, a_err}, 0);
        check("rst_rdata", {24'd0, a_rdata}, 0);
        check("rst_sel", {23'd0, a_pps, a_pulse, a_mem}, 0);
        check("rst_strobe", {30'd0, a_wr, a_rd}, 0);
        check("rst_addr_wdata", {18'd0, a_addr, a_wdata}, 0);
        rst_n = 1'b1;

        issue(1'b1, 8'h25, 8'hA5, 8'h00, 0);
        issue(1'b0, 8'h53, 8'h00, 8'h3C, 0);
        issue(1'b0, 8'hBF, 8'h00, 8'h96, 0);
        issue(1'b0, 8'hC7, 8'h00, 8'h11, 0);
        issue(1'b1, 8'hF0, 8'h5E, 8'h00, 0);
        issue(1'b1, 8'h9A, 8'h42, 8'h00, 2);

        // Request pulse during WAIT must be ignored
        issue(1'b0, 8'h61, 8'h00, 8'h5A, 0);
        @(negedge clk);
        check("busy_in_wait", {31'd0, a_busy}, 1);
        req = 1'b1; we = 1'b1; addr = 8'h00; wdata = 8'hFF;
        @(negedge clk);
        req = 1'b0;

        for (int n = 0; n < 10; n++) begin
            issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 0);
        end

        // Abort a read in WAIT with reset
        issue(1'b0, 8'h34, 8'h00, 8'h7E, 0);
        issue(1'b0, 8'h43, 8'h00, 8'hC3, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, a_busy}, 0);
        check("abort_ack", {31'd0, a_ack}, 0);
        check("abort_rdata", {24'd0, a_rdata}, 0);
        check("abort_sel", {23'd0, a_pps, a_pulse, a_mem}, 0);
        check("abort_strobe", {30'd0, a_wr, a_rd}, 0);
        check("abort_addr", {26'd0, a_addr}, 0);
        ack_q.delete();
        stb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 8'h12, 8'h00, 8'hE1, 0);

        drained = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ack_q.size() == 0 && stb_q.size() == 0 && !a_busy) begin
                drained = 1;
                break;
            end
        end
        check("drained", drained, 1);
        check("pending_acks", ack_q.size(), 0);

        // Memory read on the latency-4 build
        @(negedge clk);
        check("b_idle", {31'd0, b_busy}, 0);
        we = 1'b0; addr = 8'hBF; rd_value = 8'h77; req_b = 1'b1;
        c0_b = cyc;
        @(negedge clk);
        req_b = 1'b0;
        check("b_mem_sel", {31'd0, b_mem}, 1);
        check("b_rd_en", {31'd0, b_rd}, 1);
        check("b_wr_en", {31'd0, b_wr}, 0);
        check("b_addr", {26'd0, b_addr}, 32'h3F);
        check("b_other_sel", {24'd0, b_pps, b_pulse}, 0);
        got_b = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_ack) begin
                got_b = 1;
                break;
            end
        end
        check("b_ack_seen", got_b, 1);
        check("b_ack_cycle", cyc, c0_b + RL_B + 2);
        check("b_rdata", {24'd0, b_rdata}, 32'h77);
        check("b_err", {31'd0, b_err}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
